muldiv_unit: RTL and testbench

// - Iterative RV32M multiply/divide unit beside the single-cycle ALU; consumes raw funct3 and

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign of the result is applied on the transition into DONE.
// Optional build macro MULDIV_FAST_MUL_EN: the four multiply ops use a
// single-cycle product and go straight from IDLE to DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic               a_sgn, b_sgn, neg_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] mul_step, div_step;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // Turns the magnitude accumulator into the architectural result.
  // Multiply: acc holds the full product. Divide: acc = {remainder, quotient}.
  function automatic logic [WIDTH-1:0] fixup(input logic [2:0] op, input logic neg,
                                              input logic [2*WIDTH-1:0] acc);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   lo, hi;
    p  = neg ? -acc : acc;
    lo = acc[WIDTH-1:0];
    hi = acc[2*WIDTH-1:WIDTH];
    case (op)
      3'd0:             fixup = lo;
      3'd1, 3'd2, 3'd3: fixup = p[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fixup = neg ? -lo : lo;
      default:          fixup = neg ? -hi : hi;
    endcase
  endfunction

  // Operand signedness, magnitudes, and one iteration of each datapath.
  always_comb begin
    a_sgn  = ((funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6))
             && A[WIDTH-1];
    b_sgn  = ((funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6)) && B[WIDTH-1];
    a_mag  = a_sgn ? -A : A;
    b_mag  = b_sgn ? -B : B;
    // Quotient/product sign is the XOR of operand signs; remainder follows the dividend.
    if ((funct3 == 3'd1) || (funct3 == 3'd4)) neg_in = a_sgn ^ b_sgn;
    else if ((funct3 == 3'd2) || (funct3 == 3'd6)) neg_in = a_sgn;
    else neg_in = 1'b0;

    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_step = {msum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};
    if (!trial[WIDTH]) div_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else               div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
  end

  // Next-state, capture and result logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          neg_d = neg_in;
          b_d   = b_mag;
          cnt_d = '0;
          if (funct3[2] && (B == '0)) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? A : '1;
          end else if (((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                       (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1)) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? '0 : A;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!funct3[2]) begin
            state_d  = S_DONE;
            result_d = fixup(funct3, neg_in, fast_prod);
`endif
          end else begin
            state_d = S_CALC;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = fixup(op_q, neg_q, acc_d);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    zero_d = (result_d == '0);
  end

  // State registers with synchronous reset; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed corner cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .A(A), .B(B), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = 64'(ua) * 64'(ub); return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (FAST && !op[2]) return 1;
    return 33;
  endfunction

  // One operation: accept, scramble the inputs, wait for done, check everything.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    exp = ref_model(op, a, b);
    @(negedge clk);
    funct3 = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; funct3 = 3'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat(op, a, b));
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 0));
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int pulses, t1, t2, cyc;
    logic [31:0] r1, exp1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;

    // Directed corner cases
    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu", 3'd5, 32'hFFFF_FFFF, 32'd16);
    do_op("div0", 3'd4, 32'd5, 32'd0);
    do_op("remu0", 3'd7, 32'd5, 32'd0);
    do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // start mid-CALC is ignored; exactly one done pulse with the first result
    exp1 = ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    funct3 = 3'd1; A = 32'h1234_5678; B = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    funct3 = 3'd5; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; r1 = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin pulses++; r1 = result; end
      @(posedge clk); #1;
    end
    check("midcalc_pulses", pulses, 32'd1);
    check("midcalc_res", r1, (FAST ? ref_model(3'd5, 32'd100, 32'd7) : exp1));

    // start held high: DONE-cycle start ignored, next accept in the following IDLE cycle
    @(negedge clk);
    funct3 = 3'd5; A = 32'd1_000_000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    t1 = -1; t2 = -1; cyc = 1;
    while (t2 < 0 && cyc < 120) begin
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else begin t2 = cyc; start = 1'b0; end
      end
      if (t2 < 0) begin @(posedge clk); #1; cyc++; end
    end
    check("b2b_first", t1, 32'd33);
    check("b2b_second", t2, 32'd67);
    check("b2b_res", result, 32'd333_333);
    @(posedge clk); #1;
    check("b2b_idle", 32'(busy), 32'd0);

    // reset at CALC count 10 aborts the operation
    @(negedge clk);
    funct3 = 3'd4; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    do_op("divu_after", 3'd5, 32'd100, 32'd7);

    // Randomized operations with biased corner operands
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int sel;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'd1;
      else if (sel == 3) b = b >> $urandom_range(0, 31);
      do_op("rand", op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
